// File: rtl/mc16_prog_loader.sv
// mc16_prog_loader
//   Byte-wide program loader for the microcore16 core. Receives a framed
//   image (LEN, LEN x {HI, LO}, SUM) over an 8-bit strobed port, writes the
//   assembled big-endian words into instruction memory and holds the core in
//   reset until a frame completes with a matching XOR checksum.
//
// Ports
//   clk        system clock (shared with the core)
//   rst        asynchronous active-high reset
//   load_mode  asynchronous request to enter load mode
//   byte_in    data byte, stable while byte_strb is high
//   byte_strb  asynchronous byte strobe; rising edge captures byte_in
//   mem_we     one-cycle instruction-memory write pulse
//   mem_addr   write address (ADDR_W bits)
//   mem_wdata  write data {hi, lo}
//   core_hold  holds the core in reset while high
//   busy       frame in progress
//   done       sticky: last frame loaded with good checksum
//   err        sticky: last frame aborted or failed its checksum
//   byte_ack   toggles once per accepted byte
module mc16_prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic [7:0]        byte_in,
  input  logic              byte_strb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              byte_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_LEN, S_GET_HI, S_GET_LO, S_WRITE, S_GET_SUM, S_DONE, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] lm_sync_q, lm_sync_d;
  logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
  logic                   lm_prev_q, lm_prev_d;
  logic                   strb_prev_q, strb_prev_d;
  logic [8:0]             count_q, count_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             xor_q, xor_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [15:0]            mem_wdata_q, mem_wdata_d;
  logic                   core_hold_q, core_hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   byte_ack_q, byte_ack_d;

  logic lm_s, strb_s, lm_rise, strb_rise;

  // LEN byte of 0 encodes 256 words; the image must fit the address space.
  function automatic logic len_ok(input logic [7:0] b);
    logic [31:0] words;
    words = (b == 8'd0) ? 32'd256 : {24'd0, b};
    return words <= (32'd1 << ADDR_W);
  endfunction

  assign lm_s      = lm_sync_q[SYNC_STAGES-1];
  assign strb_s    = strb_sync_q[SYNC_STAGES-1];
  assign lm_rise   = lm_s & ~lm_prev_q;
  assign strb_rise = strb_s & ~strb_prev_q;

  always_comb begin
    lm_sync_d   = {lm_sync_q[SYNC_STAGES-2:0], load_mode};
    strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], byte_strb};
    lm_prev_d   = lm_s;
    strb_prev_d = strb_s;
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    byte_ack_d  = byte_ack_q;

    case (state_q)
      S_IDLE: begin
        if (lm_rise) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          count_d    = '0;
          mem_addr_d = '0;
          xor_d      = '0;
          state_d    = S_GET_LEN;
        end
      end
      // In every GET_* state a falling load_mode beats a same-cycle strobe.
      S_GET_LEN: begin
        if (!lm_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (strb_rise) begin
          byte_ack_d = ~byte_ack_q;
          if (len_ok(byte_in)) begin
            count_d = (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
            state_d = S_GET_HI;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_GET_HI: begin
        if (!lm_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (strb_rise) begin
          byte_ack_d = ~byte_ack_q;
          hi_d       = byte_in;
          xor_d      = xor_q ^ byte_in;
          state_d    = S_GET_LO;
        end
      end
      S_GET_LO: begin
        if (!lm_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (strb_rise) begin
          byte_ack_d  = ~byte_ack_q;
          xor_d       = xor_q ^ byte_in;
          mem_wdata_d = {hi_q, byte_in};
          mem_we_d    = 1'b1;
          state_d     = S_WRITE;
        end
      end
      // mem_we is high for exactly this state; the write itself cannot be
      // cancelled, but an abort still routes to ERR.
      S_WRITE: begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        count_d    = count_q - 9'd1;
        if (!lm_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (count_q == 9'd1) begin
          state_d = S_GET_SUM;
        end else begin
          state_d = S_GET_HI;
        end
      end
      S_GET_SUM: begin
        if (!lm_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (strb_rise) begin
          byte_ack_d = ~byte_ack_q;
          if (byte_in == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!lm_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    core_hold_d = lm_s | (state_d != S_IDLE);
    busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lm_sync_q   <= '0;
      strb_sync_q <= '0;
      lm_prev_q   <= 1'b0;
      strb_prev_q <= 1'b0;
      count_q     <= '0;
      hi_q        <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lm_sync_q   <= lm_sync_d;
      strb_sync_q <= strb_sync_d;
      lm_prev_q   <= lm_prev_d;
      strb_prev_q <= strb_prev_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      xor_q       <= xor_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      byte_ack_q  <= byte_ack_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign byte_ack  = byte_ack_q;

endmodule

// File: tb/tb_mc16_prog_loader.sv
// Testbench for mc16_prog_loader (ADDR_W=2 so the size limit is reachable).
// Stimulus pushes expected memory writes into a queue; a negedge monitor pops
// and compares on every mem_we and counts byte_ack toggles.
module tb_mc16_prog_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_mode;
  logic [7:0]    byte_in;
  logic          byte_strb;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          core_hold, busy, done, err, byte_ack;

  mc16_prog_loader #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .load_mode(load_mode), .byte_in(byte_in),
    .byte_strb(byte_strb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy), .done(done),
    .err(err), .byte_ack(byte_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t        exp_wq[$];
  logic [7:0] seq[$];
  int         checks = 0;
  int         failures = 0;
  int         ack_count = 0;
  logic       ack_prev = 1'b0;
  logic       we_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard for memory writes plus byte_ack toggle counting.
  always @(negedge clk) begin
    if (byte_ack !== ack_prev) ack_count++;
    ack_prev = byte_ack;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_wq.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || we_prev === 1'b1) begin
          failures++;
          $display("FAIL mem_write: got addr %0h data %0h (prev_we %0b) expected addr %0h data %0h one-cycle",
                   mem_addr, mem_wdata, we_prev, e.addr, e.data);
        end
      end
    end
    we_prev = mem_we;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit long_strobe);
    logic a0;
    bit   got;
    int   snap;
    snap      = ack_count;
    a0        = byte_ack;
    got       = 1'b0;
    byte_in   = b;
    byte_strb = 1'b1;
    if (long_strobe) begin
      wait_cyc(10);
      byte_strb = 1'b0;
      wait_cyc(4);
      chk("long_strobe_one_byte", ack_count - snap, 1);
    end else begin
      for (int c = 0; c < 20 && !got; c++) begin
        wait_cyc(1);
        if (byte_ack !== a0) got = 1'b1;
      end
      chk("byte_ack_toggle", {31'd0, got}, 1);
      byte_strb = 1'b0;
      wait_cyc(4);
    end
  endtask

  // Reference model + host driver for one frame held in seq[].
  // abort_at: index of the byte before which load_mode is dropped (-1: none).
  task automatic do_frame(input int abort_at, input bit long_first, input string nm);
    int         lw, nsend, nsent, snap;
    bit         legal, aborted, exp_done;
    logic [7:0] x;
    lw    = (seq[0] == 8'd0) ? 256 : int'(seq[0]);
    legal = (lw <= (1 << AW));
    nsend = legal ? 2 + 2 * lw : 1;
    x     = 8'd0;
    if (legal) for (int i = 1; i <= 2 * lw; i++) x ^= seq[i];
    aborted  = (abort_at >= 0) && (abort_at < nsend);
    nsent    = aborted ? abort_at : nsend;
    exp_done = legal && !aborted && (seq[nsend-1] == x);
    if (legal) begin
      for (int i = 0; i < lw; i++) begin
        if (2 + 2 * i < nsent) begin
          wr_t w;
          w.addr = AW'(i);
          w.data = {seq[1+2*i], seq[2+2*i]};
          exp_wq.push_back(w);
        end
      end
    end
    snap      = ack_count;
    load_mode = 1'b1;
    wait_cyc(4);
    chk({nm, "_busy_start"}, {31'd0, busy}, 1);
    chk({nm, "_flags_cleared"}, {30'd0, done, err}, 0);
    for (int k = 0; k < nsent; k++) send_byte(seq[k], long_first && k == 0);
    if (aborted) begin
      load_mode = 1'b0;
      wait_cyc(8);
    end else begin
      wait_cyc(3);
      chk({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
      chk({nm, "_err"}, {31'd0, err}, {31'd0, !exp_done});
      chk({nm, "_hold_while_lm"}, {31'd0, core_hold}, 1);
      chk({nm, "_busy_end"}, {31'd0, busy}, 0);
      load_mode = 1'b0;
      wait_cyc(6);
    end
    chk({nm, "_done_sticky"}, {31'd0, done}, {31'd0, exp_done});
    chk({nm, "_err_sticky"}, {31'd0, err}, {31'd0, !exp_done});
    chk({nm, "_idle_busy"}, {31'd0, busy}, 0);
    chk({nm, "_hold_released"}, {31'd0, core_hold}, 0);
    chk({nm, "_ack_count"}, ack_count - snap, nsent);
    chk({nm, "_writes_drained"}, exp_wq.size(), 0);
    exp_wq.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({nm, "_mem_addr"}, {30'd0, mem_addr}, 0);
    chk({nm, "_mem_wdata"}, {16'd0, mem_wdata}, 0);
    chk({nm, "_core_hold"}, {31'd0, core_hold}, 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_done"}, {31'd0, done}, 0);
    chk({nm, "_err"}, {31'd0, err}, 0);
    chk({nm, "_byte_ack"}, {31'd0, byte_ack}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, ab, lw;
    logic [7:0] b, x, s;
    rst = 1'b1; load_mode = 1'b0; byte_in = 8'd0; byte_strb = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(3);
    check_reset_outputs("post_reset");

    // Good frame.
    seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    do_frame(-1, 1'b0, "good");
    // Bad checksum: both writes still happen, 6 acks.
    seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    do_frame(-1, 1'b0, "badsum");
    // Abort after HI byte of word 1.
    seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    do_frame(4, 1'b0, "abort");
    // Size limits.
    seq = '{8'h05};
    do_frame(-1, 1'b0, "len5");
    seq = '{8'h00};
    do_frame(-1, 1'b0, "len0");
    seq = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    do_frame(-1, 1'b1, "len4_long_strobe");

    // Strobes while idle are ignored.
    snap = ack_count;
    for (int i = 0; i < 3; i++) begin
      byte_in = 8'hA5; byte_strb = 1'b1; wait_cyc(4);
      byte_strb = 1'b0; wait_cyc(4);
    end
    chk("idle_strobe_no_ack", ack_count - snap, 0);
    chk("idle_strobe_busy", {31'd0, busy}, 0);

    // Async reset during GET_LO.
    load_mode = 1'b1;
    wait_cyc(4);
    send_byte(8'h02, 1'b0);
    send_byte(8'h55, 1'b0);
    #2 rst = 1'b1; load_mode = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    do_frame(-1, 1'b0, "after_reset");

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int r;
      seq.delete();
      r = $urandom_range(0, 9);
      if (r < 7) begin
        lw = $urandom_range(1, 4);
        seq.push_back(8'(lw));
      end else if (r == 7) begin
        lw = 256;
        seq.push_back(8'h00);
      end else begin
        lw = $urandom_range(5, 255);
        seq.push_back(8'(lw));
      end
      if (lw <= 4) begin
        x = 8'd0;
        for (int i = 0; i < 2 * lw; i++) begin
          b = 8'($urandom);
          seq.push_back(b);
          x ^= b;
        end
        s = x;
        if ($urandom_range(0, 3) == 0) s = x ^ 8'($urandom_range(1, 255));
        seq.push_back(s);
      end
      ab = -1;
      if ($urandom_range(0, 4) == 0) ab = $urandom_range(0, seq.size() - 1);
      do_frame(ab, 1'b0, $sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
